instruction_fetch_unit: RTL and testbench

- Supplies the 16-bit instruction word, with a valid/ready handshake, to the instruction decoder of the accumulator CPU.
- Owns the program counter and issues read requests to instruction memory over a request/grant/response interface.
- Holds fetched words in a small prefetch FIFO.
- Handles control-flow redirects by flushing the FIFO and discarding stale responses.

---
 rtl/instruction_fetch_unit_if.sv | 31 +++
 rtl/instruction_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle for the instruction fetch unit: the memory request/grant/response
// channel plus the instruction handshake towards the decoder.
// master = fetch unit side, slave = memory/decoder environment side.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 16
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_gnt;
  logic               mem_rvalid;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic [ADDR_W-1:0]  instr_pc;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output instr, instr_valid, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  instr, instr_valid, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit for the accumulator CPU: owns the PC, fetches one
// word at a time from instruction memory into a small prefetch FIFO, and
// flushes/drops stale data on control-flow redirects.
// Optional: define IFU_PERF_CNT_EN to add a saturating retired-word counter
// on output retired_count_o.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 10,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic              busy_o,
`ifdef IFU_PERF_CNT_EN
  output logic [15:0]       retired_count_o,
`endif
  instruction_fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  fetchPc_q, fetchPc_d;
  logic [ADDR_W-1:0]  memAddr_q, memAddr_d;
  logic               memReq_q, memReq_d;
  logic               drop_q, drop_d;

  logic [INSTR_W-1:0] fifoData_q [DEPTH];
  logic [ADDR_W-1:0]  fifoPc_q   [DEPTH];
  logic [PTR_W-1:0]   wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]   count_q;

  logic               push;
  logic               pop;
  logic               slotFree;

  // A redirect throws away any same-cycle pop along with the rest of the FIFO.
  assign pop      = bus.instr_valid & bus.instr_ready & ~redirect_i;
  assign slotFree = (count_q - {{(CNT_W-1){1'b0}}, pop}) < DEPTH_C;

  // Fetch FSM: one outstanding request at a time, redirect takes priority.
  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    memAddr_d = memAddr_q;
    memReq_d  = memReq_q;
    drop_d    = drop_q;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_i) begin
          fetchPc_d = redirect_addr_i;
        end else if (enable_i && slotFree) begin
          memReq_d  = 1'b1;
          memAddr_d = fetchPc_q;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (redirect_i) begin
          fetchPc_d = redirect_addr_i;
          drop_d    = 1'b1;
        end
        if (bus.mem_gnt) begin
          memReq_d = 1'b0;
          state_d  = WAIT;
          // drop_q set here means the PC was already retargeted by a redirect.
          if (!redirect_i && !drop_q) begin
            fetchPc_d = fetchPc_q + 1'b1;
          end
        end
      end
      WAIT: begin
        if (redirect_i) begin
          fetchPc_d = redirect_addr_i;
        end
        if (bus.mem_rvalid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          push    = !drop_q && !redirect_i;
        end else if (redirect_i) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch state registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      fetchPc_q <= RESET_PC;
      memAddr_q <= RESET_PC;
      memReq_q  <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      memAddr_q <= memAddr_d;
      memReq_q  <= memReq_d;
      drop_q    <= drop_d;
    end
  end

  // Prefetch FIFO: entries carry the word and the address it came from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifoData_q[i] <= '0;
        fifoPc_q[i]   <= '0;
      end
    end else if (redirect_i) begin
      rdPtr_q <= wrPtr_q;
      count_q <= '0;
    end else begin
      if (push) begin
        fifoData_q[wrPtr_q] <= bus.mem_rdata;
        fifoPc_q[wrPtr_q]   <= memAddr_q;
        wrPtr_q             <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.mem_req     = memReq_q;
  assign bus.mem_addr    = memAddr_q;
  assign bus.instr       = fifoData_q[rdPtr_q];
  assign bus.instr_pc    = fifoPc_q[rdPtr_q];
  assign bus.instr_valid = (count_q != '0);
  assign busy_o          = (state_q != IDLE);

`ifdef IFU_PERF_CNT_EN
  logic [15:0] retiredCount_q;

  // Count delivered words only, saturating instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retiredCount_q <= '0;
    end else if (pop && (retiredCount_q != 16'hFFFF)) begin
      retiredCount_q <= retiredCount_q + 16'd1;
    end
  end

  assign retired_count_o = retiredCount_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit (RESET_PC = 0x010, DEPTH = 2).
// Checks the retired-word counter as well when IFU_PERF_CNT_EN is defined.
module tb_instruction_fetch_unit;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       redirect;
  logic [9:0] redirectAddr;
  logic       busy;
`ifdef IFU_PERF_CNT_EN
  logic [15:0] retiredCount;
`endif

  int nChecks = 0;
  int nFails  = 0;

  // Memory responder knobs and bookkeeping
  int         gntDelay = 0;
  int         respLat  = 1;
  int         reqWait  = 0;
  int         respCnt  = 0;
  logic [9:0] respAddr = '0;
  logic [9:0] grantAddr = '0;
  logic [9:0] grantLog[$];

  instruction_fetch_unit_if #(.ADDR_W(10), .INSTR_W(16)) bus ();

  instruction_fetch_unit #(
    .ADDR_W(10), .INSTR_W(16), .DEPTH(2), .RESET_PC(10'h010)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable_i(enable),
    .redirect_i(redirect),
    .redirect_addr_i(redirectAddr),
    .busy_o(busy),
`ifdef IFU_PERF_CNT_EN
    .retired_count_o(retiredCount),
`endif
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] memWord(input logic [9:0] a);
    return 16'hA000 + {6'd0, a};
  endfunction

  // Memory model: grants after gntDelay waiting cycles, answers respLat cycles after grant.
  always @(negedge clk) begin
    if (bus.mem_gnt) begin
      respCnt  = respLat;
      respAddr = grantAddr;
    end
    bus.mem_rvalid = 1'b0;
    if (respCnt > 0) begin
      respCnt--;
      if (respCnt == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = memWord(respAddr);
      end
    end
    if (bus.mem_req) begin
      if (reqWait >= gntDelay) begin
        bus.mem_gnt = 1'b1;
        grantAddr   = bus.mem_addr;
        grantLog.push_back(bus.mem_addr);
        reqWait     = 0;
      end else begin
        bus.mem_gnt = 1'b0;
        reqWait++;
      end
    end else begin
      bus.mem_gnt = 1'b0;
      reqWait     = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReq(input int budget, output bit ok);
    int n = 0;
    while (!bus.mem_req && n < budget) begin tick(); n++; end
    ok = bus.mem_req;
  endtask

  task automatic waitValid(input int budget, output bit ok);
    int n = 0;
    while (!bus.instr_valid && n < budget) begin tick(); n++; end
    ok = bus.instr_valid;
  endtask

  function automatic logic [10:0] logAt(input int k);
    return (grantLog.size() > k) ? {1'b0, grantLog[k]} : 11'h7FF;
  endfunction

  // Stop fetching, let any in-flight request finish, then flush and retarget the PC.
  task automatic quiesce(input logic [9:0] addr);
    int n = 0;
    enable = 1'b0;
    bus.instr_ready = 1'b0;
    while (busy && n < 40) begin tick(); n++; end
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL quiesce_idle: busy got %0b expected 0", busy); end
    redirect = 1'b1;
    redirectAddr = addr;
    tick();
    redirect = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    $display("[TB] test_reset");
    nChecks++; if (bus.mem_req !== 1'b0) begin nFails++; $display("[TB] FAIL rst_mem_req: got %0b expected 0", bus.mem_req); end
    nChecks++; if (bus.mem_addr !== 10'h010) begin nFails++; $display("[TB] FAIL rst_mem_addr: got %h expected 010", bus.mem_addr); end
    nChecks++; if (bus.instr !== 16'h0000) begin nFails++; $display("[TB] FAIL rst_instr: got %h expected 0000", bus.instr); end
    nChecks++; if (bus.instr_pc !== 10'h000) begin nFails++; $display("[TB] FAIL rst_instr_pc: got %h expected 000", bus.instr_pc); end
    nChecks++; if (bus.instr_valid !== 1'b0) begin nFails++; $display("[TB] FAIL rst_instr_valid: got %0b expected 0", bus.instr_valid); end
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL rst_busy: got %0b expected 0", busy); end
    rst = 1'b0;
    enable = 1'b1;
    tick();
    nChecks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 10'h010) begin nFails++; $display("[TB] FAIL first_req: got req=%0b addr=%h expected req=1 addr=010", bus.mem_req, bus.mem_addr); end
    tick();
    nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL wait_busy: got %0b expected 1", busy); end
    rst = 1'b1;
    #1;
    nChecks++; if (bus.mem_req !== 1'b0 || busy !== 1'b0 || bus.mem_addr !== 10'h010 || bus.instr_valid !== 1'b0) begin nFails++; $display("[TB] FAIL midwait_rst: got req=%0b busy=%0b addr=%h valid=%0b expected 0 0 010 0", bus.mem_req, busy, bus.mem_addr, bus.instr_valid); end
    #1;
    rst = 1'b0;
    enable = 1'b0;
    tick();
    nChecks++; if (bus.instr_valid !== 1'b0 || busy !== 1'b0) begin nFails++; $display("[TB] FAIL stray_rvalid: got valid=%0b busy=%0b expected 0 0", bus.instr_valid, busy); end
    enable = 1'b1;
    tick();
    nChecks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 10'h010) begin nFails++; $display("[TB] FAIL refetch_req: got req=%0b addr=%h expected req=1 addr=010", bus.mem_req, bus.mem_addr); end
    waitValid(20, ok);
    nChecks++; if (bus.instr_pc !== 10'h010 || bus.instr !== 16'hA010) begin nFails++; $display("[TB] FAIL first_word: got pc=%h instr=%h expected pc=010 instr=a010", bus.instr_pc, bus.instr); end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    waitValid(20, ok);
    nChecks++; if (bus.instr_pc !== 10'h011 || bus.instr !== 16'hA011) begin nFails++; $display("[TB] FAIL second_word: got pc=%h instr=%h expected pc=011 instr=a011", bus.instr_pc, bus.instr); end
  endtask

  task automatic test_backpressure();
    $display("[TB] test_backpressure");
    quiesce(10'h000);
    grantLog.delete();
    enable = 1'b1;
    repeat (15) tick();
    nChecks++; if (grantLog.size() != 2) begin nFails++; $display("[TB] FAIL bp_grants: got %0d expected 2", grantLog.size()); end
    nChecks++; if (logAt(0) !== 11'h000 || logAt(1) !== 11'h001) begin nFails++; $display("[TB] FAIL bp_addrs: got %h %h expected 000 001", logAt(0), logAt(1)); end
    nChecks++; if (bus.mem_req !== 1'b0 || busy !== 1'b0) begin nFails++; $display("[TB] FAIL bp_stall: got req=%0b busy=%0b expected 0 0", bus.mem_req, busy); end
    nChecks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 10'h000 || bus.instr !== 16'hA000) begin nFails++; $display("[TB] FAIL bp_head: got valid=%0b pc=%h instr=%h expected 1 000 a000", bus.instr_valid, bus.instr_pc, bus.instr); end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    nChecks++; if (bus.instr_pc !== 10'h001) begin nFails++; $display("[TB] FAIL bp_pop: got pc=%h expected 001", bus.instr_pc); end
    nChecks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 10'h002) begin nFails++; $display("[TB] FAIL bp_refill_req: got req=%0b addr=%h expected req=1 addr=002", bus.mem_req, bus.mem_addr); end
    repeat (10) tick();
    nChecks++; if (grantLog.size() != 3 || logAt(2) !== 11'h002) begin nFails++; $display("[TB] FAIL bp_third: got n=%0d addr=%h expected n=3 addr=002", grantLog.size(), logAt(2)); end
    nChecks++; if (bus.mem_req !== 1'b0 || bus.instr_pc !== 10'h001) begin nFails++; $display("[TB] FAIL bp_full_again: got req=%0b pc=%h expected 0 001", bus.mem_req, bus.instr_pc); end
  endtask

  task automatic test_gnt_delay_redirect();
    bit ok;
    $display("[TB] test_gnt_delay_redirect");
    quiesce(10'h100);
    gntDelay = 3;
    respLat  = 3;
    enable   = 1'b1;
    waitReq(10, ok);
    nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL gd_req_timeout: got req=0 expected 1"); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      nChecks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 10'h100) begin nFails++; $display("[TB] FAIL gd_hold%0d: got req=%0b addr=%h expected 1 100", k, bus.mem_req, bus.mem_addr); end
    end
    tick();
    nChecks++; if (bus.mem_req !== 1'b0 || busy !== 1'b1) begin nFails++; $display("[TB] FAIL gd_granted: got req=%0b busy=%0b expected 0 1", bus.mem_req, busy); end
    redirect = 1'b1;
    redirectAddr = 10'h200;
    tick();
    redirect = 1'b0;
    nChecks++; if (bus.instr_valid !== 1'b0 || busy !== 1'b1) begin nFails++; $display("[TB] FAIL gd_redirect_wait: got valid=%0b busy=%0b expected 0 1", bus.instr_valid, busy); end
    tick();
    tick();
    gntDelay = 0;
    respLat  = 1;
    nChecks++; if (bus.instr_valid !== 1'b0) begin nFails++; $display("[TB] FAIL gd_stale_dropped: got valid=%0b pc=%h expected valid=0", bus.instr_valid, bus.instr_pc); end
    waitReq(10, ok);
    nChecks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 10'h200) begin nFails++; $display("[TB] FAIL gd_new_req: got req=%0b addr=%h expected 1 200", bus.mem_req, bus.mem_addr); end
    waitValid(20, ok);
    nChecks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 10'h200 || bus.instr !== 16'hA200) begin nFails++; $display("[TB] FAIL gd_new_word: got valid=%0b pc=%h instr=%h expected 1 200 a200", bus.instr_valid, bus.instr_pc, bus.instr); end
  endtask

  task automatic test_redirect_pop();
    bit ok;
    $display("[TB] test_redirect_pop");
    quiesce(10'h020);
    enable = 1'b1;
    repeat (12) tick();
    enable = 1'b0;
    repeat (4) tick();
    nChecks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 10'h020) begin nFails++; $display("[TB] FAIL rp_queued: got valid=%0b pc=%h expected 1 020", bus.instr_valid, bus.instr_pc); end
    bus.instr_ready = 1'b1;
    redirect = 1'b1;
    redirectAddr = 10'h040;
    tick();
    redirect = 1'b0;
    nChecks++; if (bus.instr_valid !== 1'b0) begin nFails++; $display("[TB] FAIL rp_flushed: got valid=%0b expected 0", bus.instr_valid); end
    repeat (3) tick();
    nChecks++; if (bus.instr_valid !== 1'b0) begin nFails++; $display("[TB] FAIL rp_no_reappear: got valid=%0b pc=%h expected valid=0", bus.instr_valid, bus.instr_pc); end
    enable = 1'b1;
    waitValid(20, ok);
    nChecks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 10'h040) begin nFails++; $display("[TB] FAIL rp_new_head: got valid=%0b pc=%h expected 1 040", bus.instr_valid, bus.instr_pc); end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_enable_drop();
    bit ok;
    bit sawReq;
    $display("[TB] test_enable_drop");
    quiesce(10'h050);
    grantLog.delete();
    gntDelay = 2;
    enable = 1'b1;
    waitReq(10, ok);
    nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL ed_req_timeout: got req=0 expected 1"); end
    enable = 1'b0;
    waitValid(20, ok);
    gntDelay = 0;
    nChecks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 10'h050 || bus.instr !== 16'hA050) begin nFails++; $display("[TB] FAIL ed_word: got valid=%0b pc=%h instr=%h expected 1 050 a050", bus.instr_valid, bus.instr_pc, bus.instr); end
    sawReq = 1'b0;
    repeat (8) begin
      tick();
      if (bus.mem_req) sawReq = 1'b1;
    end
    nChecks++; if (sawReq !== 1'b0 || busy !== 1'b0) begin nFails++; $display("[TB] FAIL ed_quiet: got sawReq=%0b busy=%0b expected 0 0", sawReq, busy); end
    nChecks++; if (grantLog.size() != 1) begin nFails++; $display("[TB] FAIL ed_grants: got %0d expected 1", grantLog.size()); end
  endtask

  task automatic test_wrap_perf();
    logic [9:0] pcLog[$];
    int n = 0;
    int cyc = 0;
    $display("[TB] test_wrap_perf");
    rst = 1'b1;
    enable = 1'b0;
    tick();
`ifdef IFU_PERF_CNT_EN
    nChecks++; if (retiredCount !== 16'd0) begin nFails++; $display("[TB] FAIL perf_reset: got %0d expected 0", retiredCount); end
`endif
    rst = 1'b0;
    quiesce(10'h3FF);
    grantLog.delete();
    bus.instr_ready = 1'b1;
    enable = 1'b1;
    while (n < 5 && cyc < 60) begin
      if (bus.instr_valid) begin
        pcLog.push_back(bus.instr_pc);
        n++;
      end
      tick();
      cyc++;
    end
    bus.instr_ready = 1'b0;
    enable = 1'b0;
    nChecks++; if (n != 5) begin nFails++; $display("[TB] FAIL wrap_handshakes: got %0d expected 5", n); end
    nChecks++; if (logAt(0) !== 11'h3FF || logAt(1) !== 11'h000) begin nFails++; $display("[TB] FAIL wrap_fetch_addrs: got %h %h expected 3ff 000", logAt(0), logAt(1)); end
    nChecks++; if (pcLog.size() < 2 || pcLog[0] !== 10'h3FF || pcLog[1] !== 10'h000) begin nFails++; $display("[TB] FAIL wrap_instr_pc: got n=%0d expected 3ff then 000", pcLog.size()); end
`ifdef IFU_PERF_CNT_EN
    nChecks++; if (retiredCount !== 16'd5) begin nFails++; $display("[TB] FAIL perf_count: got %0d expected 5", retiredCount); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    redirect = 1'b0;
    redirectAddr = '0;
    bus.instr_ready = 1'b0;
    repeat (3) tick();
    test_reset();
    test_backpressure();
    test_gnt_delay_redirect();
    test_redirect_pop();
    test_enable_drop();
    test_wrap_perf();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
